led_matrix_column_scanner: RTL and testbench
============================================

Name: led_matrix_column_scanner

Overview:
- Time-multiplexes the 5-column x 7-row water tank LED matrix.
- Consumes the five 7-bit rows_status patterns from the per-column water tank level decoders and drives one column at a time with its row pattern.
- Snapshots all five patterns once per frame so a tank level change mid-frame never tears the image.
- Inserts a blanking interval before each column to prevent ghosting.

Parameters:
DIVIDER, 1000, clock cycles per column slot (blank + drive); legal range 2..65535.
BLANK_CYCLES, 50, cycles of blanking at the start of each slot; legal range 1..DIVIDER-1.
ROW_ACTIVE_LOW, 0, 1 inverts the rows output polarity (the off value becomes 7'h7F).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  scanning runs while high
col0_rows  input  7  rows_status from column 0 decoder (bit0 = row 0)
col1_rows  input  7  rows_status from column 1 decoder
col2_rows  input  7  rows_status from column 2 decoder
col3_rows  input  7  rows_status from column 3 decoder
col4_rows  input  7  rows_status from column 4 decoder
columns  output  5  column drive, one-hot-zero, active-low (bit n low = column n lit)
rows  output  7  row drive for the active column, polarity per ROW_ACTIVE_LOW
frame_start  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset is asynchronous and active-high. Reset state:
  - state = IDLE, col_index = 0, slot counter = 0, all five snapshot registers = 0.
  - Outputs: columns = 5'b11111, rows = off value, frame_start = 0.
- All outputs are registered and update on the same edge as the state transition. There are no combinational paths from inputs to outputs.
- The "off" value for rows is 7'h00 when ROW_ACTIVE_LOW = 0 and 7'h7F when ROW_ACTIVE_LOW = 1.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs are off.
  - When enable is sampled high, go to BLANK with col_index = 0.
  - On that same edge, capture col0..col4_rows into the snapshot and assert frame_start for exactly one cycle.
- BLANK:
  - columns = 5'b11111, rows = off value.
  - Lasts exactly BLANK_CYCLES clocks, then goes to DRIVE.
- DRIVE:
  - columns has bit col_index low and all other bits high.
  - rows = snapshot[col_index], inverted when ROW_ACTIVE_LOW = 1.
  - Lasts exactly DIVIDER - BLANK_CYCLES clocks, then goes to BLANK with col_index + 1.
- Wrap-around:
  - Leaving DRIVE with col_index = 4 sets col_index = 0.
  - On that edge, re-capture the snapshot and pulse frame_start.
  - Frame period = 5 x DIVIDER clocks; frame_start period is the same.
- Snapshot rule: inputs are sampled only on frame-start edges. Input changes at any other time do not affect the current frame.
- enable low, sampled in BLANK or DRIVE: on the next edge go to IDLE, outputs off, col_index = 0, counter = 0. The aborted frame is not completed.
- enable re-asserted: always restarts from column 0 with a fresh snapshot.
- Simultaneous events: enable falling on the same edge as a slot or frame wrap means IDLE wins. No frame_start is emitted and no snapshot is taken.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). On reset release with enable high, the first BLANK starts on the first clock edge after release.
- Invariant: at most one columns bit is low at any time. columns is all-high in IDLE and BLANK.
- Slot counter width is the minimum needed to hold DIVIDER-1. It counts 0..DIVIDER-1 within a slot: BLANK covers counts 0..BLANK_CYCLES-1, DRIVE covers the rest.

Test Plan:
1. Reset release, enable high, DIVIDER=8, BLANK_CYCLES=2, col0..4_rows = 7'h01,7'h02,7'h04,7'h08,7'h10:
   - frame_start pulses one cycle.
   - columns = 5'b11111 for 2 cycles, then 5'b11110 with rows=7'h01 for 6 cycles, then blank 2 cycles.
   - Next is 5'b11101 with rows=7'h02, continuing through 5'b01111 with rows=7'h10.
   - frame_start repeats every 40 cycles.
2. Same setup; change col2_rows to 7'h7F while column 1 is driving:
   - Column 2 still shows 7'h04.
   - The next frame shows 7'h7F.
3. Deassert enable during column 3 DRIVE:
   - The next edge gives columns=5'b11111 and rows=0.
   - Re-asserting enable gives frame_start and then starts at column 0.
4. Assert reset asynchronously mid-DRIVE (between clock edges):
   - columns=5'b11111, rows=0 and frame_start=0 immediately, without waiting for a clock edge.
   - After release, timing matches scenario 1.
5. ROW_ACTIVE_LOW=1 with col0_rows=7'h05:
   - rows=7'h7F in BLANK and IDLE.
   - rows=7'h7A while column 0 drives.
6. Run 100 frames with random inputs:
   - A checker asserts that columns never has more than one bit low.
   - frame_start count = 100.
   - Each DRIVE window is exactly DIVIDER-BLANK_CYCLES cycles.

Source files
------------

// File: rtl/led_matrix_column_scanner.sv
// rtl/led_matrix_column_scanner.sv - time-multiplexed column scanner for the 5x7 water tank LED matrix
module led_matrix_column_scanner #(
   parameter int unsigned DIVIDER        = 1000,
   parameter int unsigned BLANK_CYCLES   = 50,
   parameter bit          ROW_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] col0_rows,
   input  logic [6:0] col1_rows,
   input  logic [6:0] col2_rows,
   input  logic [6:0] col3_rows,
   input  logic [6:0] col4_rows,
   output logic [4:0] columns,
   output logic [6:0] rows,
   output logic       frame_start
);

   localparam int unsigned CW         = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIVIDER - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   // XOR with this both produces the off value and applies the row polarity
   localparam logic [6:0]  ROWS_OFF   = ROW_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]  COL_LAST   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_DRIVE
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       col_q, col_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [4:0][6:0]  snap_q, snap_d;
   logic [4:0]       columns_q, columns_d;
   logic [6:0]       rows_q, rows_d;
   logic             frame_start_q, frame_start_d;
   logic [4:0][6:0]  snap_in;

   assign snap_in = {col4_rows, col3_rows, col2_rows, col1_rows, col0_rows};

   // Next-state and next-output logic; outputs are computed for the state being entered
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      cnt_d         = cnt_q;
      snap_d        = snap_q;
      columns_d     = 5'b11111;
      rows_d        = ROWS_OFF;
      frame_start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d       = S_BLANK;
               col_d         = 3'd0;
               cnt_d         = '0;
               snap_d        = snap_in;
               frame_start_d = 1'b1;
            end
         end
         S_BLANK: begin
            if (!enable) begin
               state_d = S_IDLE;
               col_d   = 3'd0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == BLANK_LAST) begin
                  state_d   = S_DRIVE;
                  columns_d = ~(5'b00001 << col_q);
                  rows_d    = snap_q[col_q] ^ ROWS_OFF;
               end
            end
         end
         S_DRIVE: begin
            if (!enable) begin
               state_d = S_IDLE;
               col_d   = 3'd0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               if (col_q == COL_LAST) begin
                  // Frame wrap: new snapshot so the next frame is tear-free
                  col_d         = 3'd0;
                  snap_d        = snap_in;
                  frame_start_d = 1'b1;
               end else begin
                  col_d = col_q + 3'd1;
               end
            end else begin
               cnt_d     = cnt_q + CW'(1);
               columns_d = ~(5'b00001 << col_q);
               rows_d    = snap_q[col_q] ^ ROWS_OFF;
            end
         end
         default: begin
            state_d = S_IDLE;
            col_d   = 3'd0;
            cnt_d   = '0;
         end
      endcase
   end

   // Scanner state and registered outputs; reset blanks the matrix immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         col_q         <= 3'd0;
         cnt_q         <= '0;
         snap_q        <= '0;
         columns_q     <= 5'b11111;
         rows_q        <= ROWS_OFF;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         cnt_q         <= cnt_d;
         snap_q        <= snap_d;
         columns_q     <= columns_d;
         rows_q        <= rows_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign columns     = columns_q;
   assign rows        = rows_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// tb/tb_led_matrix_column_scanner.sv - scoreboard bench for led_matrix_column_scanner
module tb_led_matrix_column_scanner;

   localparam int D = 8;
   localparam int B = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [6:0] c0, c1, c2, c3, c4;
   logic [4:0] columns, columns_al;
   logic [6:0] rows, rows_al;
   logic       fs, fs_al;

   always #5 clk = ~clk;

   led_matrix_column_scanner #(.DIVIDER(D), .BLANK_CYCLES(B), .ROW_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .col0_rows(c0), .col1_rows(c1), .col2_rows(c2), .col3_rows(c3), .col4_rows(c4),
      .columns(columns), .rows(rows), .frame_start(fs)
   );

   led_matrix_column_scanner #(.DIVIDER(D), .BLANK_CYCLES(B), .ROW_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .reset(reset), .enable(enable),
      .col0_rows(c0), .col1_rows(c1), .col2_rows(c2), .col3_rows(c3), .col4_rows(c4),
      .columns(columns_al), .rows(rows_al), .frame_start(fs_al)
   );

   typedef struct packed {
      logic [4:0] cols;
      logic [6:0] rows;
      logic       fs;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   fs_count = 0;
   int   run_len = 0;
   bit   chk_win = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position k within the 5*D-cycle frame determines everything
   bit         m_run = 1'b0;
   int         m_k = 0;
   logic [6:0] m_snap[5];
   exp_t       m_e;
   int         m_slot, m_pos;

   always @(posedge clk) begin
      if (reset) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (enable) begin
            m_run = 1'b1;
            m_k = 0;
            m_snap = '{c0, c1, c2, c3, c4};
         end
      end else if (!enable) begin
         m_run = 1'b0;
      end else begin
         m_k = (m_k + 1) % (5 * D);
         if (m_k == 0) m_snap = '{c0, c1, c2, c3, c4};
      end
      m_e.cols = 5'h1F;
      m_e.rows = 7'h00;
      m_e.fs   = 1'b0;
      if (m_run) begin
         m_slot = m_k / D;
         m_pos  = m_k % D;
         m_e.fs = (m_k == 0);
         if (m_pos >= B) begin
            m_e.cols = ~(5'd1 << m_slot);
            m_e.rows = m_snap[m_slot];
         end
      end
      sb.push_back(m_e);
   end

   // Monitor: compares both DUTs against the model away from the active edge
   exp_t mon_e;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("columns", 32'(columns), 32'(mon_e.cols));
         check("rows", 32'(rows), 32'(mon_e.rows));
         check("frame_start", 32'(fs), 32'(mon_e.fs));
         check("columns_al", 32'(columns_al), 32'(mon_e.cols));
         check("rows_al", 32'(rows_al), 32'(mon_e.rows ^ 7'h7F));
         check("frame_start_al", 32'(fs_al), 32'(mon_e.fs));
         check("one_hot_zero", 32'($countones(~columns) <= 1), 32'd1);
         if (fs) fs_count++;
         if (columns != 5'h1F) begin
            run_len++;
         end else begin
            if (run_len > 0 && chk_win) check("drive_window", run_len, D - B);
            run_len = 0;
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bit seen;
      c0 = 7'h01; c1 = 7'h02; c2 = 7'h04; c3 = 7'h08; c4 = 7'h10;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; enable = 1'b1;
      run(80);

      // snapshot holds while a later column's input changes mid-frame
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (columns == 5'b11101) seen = 1'b1; else run(1);
      end
      check("wait_col1", 32'(seen), 32'd1);
      c2 = 7'h7F;
      run(80);

      // abort during column 3 drive, then restart
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (columns == 5'b10111) seen = 1'b1; else run(1);
      end
      check("wait_col3", 32'(seen), 32'd1);
      enable = 1'b0;
      run(5);
      enable = 1'b1;
      run(45);

      // asynchronous reset while a column is lit
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (columns != 5'h1F) seen = 1'b1; else run(1);
      end
      check("wait_drive", 32'(seen), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_columns", 32'(columns), 32'h1F);
      check("async_rows", 32'(rows), 32'h00);
      check("async_frame_start", 32'(fs), 32'd0);
      check("async_columns_al", 32'(columns_al), 32'h1F);
      check("async_rows_al", 32'(rows_al), 32'h7F);
      c0 = 7'h05;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      run(45);

      // long random run
      enable = 1'b0;
      run(3);
      fs_count = 0;
      chk_win = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 100 * 5 * D; i++) begin
         @(posedge clk);
         #1;
         c0 = 7'($urandom); c1 = 7'($urandom); c2 = 7'($urandom);
         c3 = 7'($urandom); c4 = 7'($urandom);
      end
      enable = 1'b0;
      run(3);
      chk_win = 1'b0;
      check("frame_count", fs_count, 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
